// File: rtl/top_wrapper_tang9k.sv
// UART-fronted SHA-256 engine: frames of 0x01 <payload> 0xFF are hashed as a single
// block and the 32-byte digest is sent back over the UART, H0 MSB first.
module top_wrapper_tang9k #(
  parameter int CLK_FREQ  = 27000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_rx,
  output logic uart_tx,
  output logic led0
);

  localparam int BIT_CLKS  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CW        = $clog2(BIT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CLKS - 1);
  localparam int MAX_LEN = 55;

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IV_TAB [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       rx_state_reg;
  logic            rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [CW-1:0]   rx_cnt_reg;
  logic [2:0]      rx_bit_reg;
  logic [7:0]      rx_shift_reg;
  logic            rx_valid_reg;
  logic [7:0]      rx_byte_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_valid_reg <= 1'b0;
      rx_byte_reg  <= '0;
    end else begin
      rx_meta_reg  <= uart_rx;
      rx_sync_reg  <= rx_meta_reg;
      rx_prev_reg  <= rx_sync_reg;
      rx_valid_reg <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_prev_reg && !rx_sync_reg) begin
            rx_state_reg <= RX_START;
            rx_cnt_reg   <= '0;
          end
        end
        RX_START: begin
          // a glitch shorter than half a bit drops back to idle
          if (rx_cnt_reg == HALF_LAST) begin
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
            rx_bit_reg   <= rx_bit_reg + 1'b1;
            if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= RX_IDLE;
            if (rx_sync_reg) begin
              rx_valid_reg <= 1'b1;
              rx_byte_reg  <= rx_shift_reg;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  // ---------------- payload buffer ----------------
  typedef enum logic [2:0] {IDLE, RECV, PAD, HASH, SEND} state_t;

  state_t      state_reg;
  logic [5:0]  len_reg;
  logic [7:0]  payload_reg [0:MAX_LEN-1];
  logic        buf_clr, buf_wr;

  assign buf_clr = rx_valid_reg && (rx_byte_reg == 8'h01) &&
                   ((state_reg == IDLE) || (state_reg == RECV));
  assign buf_wr  = rx_valid_reg && (state_reg == RECV) &&
                   (rx_byte_reg != 8'h01) && (rx_byte_reg != 8'hff) &&
                   (len_reg < 6'(MAX_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) payload_reg[i] <= '0;
    end else if (buf_clr) begin
      for (int i = 0; i < MAX_LEN; i++) payload_reg[i] <= '0;
    end else if (buf_wr) begin
      payload_reg[len_reg] <= rx_byte_reg;
    end
  end

  // ---------------- padded block ----------------
  logic [7:0]  blk_byte [0:63];
  logic [31:0] blk_word [0:15];
  logic [15:0] bit_len;

  assign bit_len = {7'd0, len_reg, 3'd0};

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_blk_byte
      if (gi < MAX_LEN) begin : g_data
        assign blk_byte[gi] = (len_reg > 6'(gi))  ? payload_reg[gi] :
                              (len_reg == 6'(gi)) ? 8'h80 : 8'h00;
      end else if (gi == MAX_LEN) begin : g_last_marker
        assign blk_byte[gi] = (len_reg == 6'(MAX_LEN)) ? 8'h80 : 8'h00;
      end else if (gi == 62) begin : g_len_hi
        assign blk_byte[gi] = bit_len[15:8];
      end else if (gi == 63) begin : g_len_lo
        assign blk_byte[gi] = bit_len[7:0];
      end else begin : g_zero
        assign blk_byte[gi] = 8'h00;
      end
    end
    for (gi = 0; gi < 16; gi++) begin : g_blk_word
      assign blk_word[gi] = {blk_byte[4*gi], blk_byte[4*gi+1], blk_byte[4*gi+2], blk_byte[4*gi+3]};
    end
  endgenerate

  // ---------------- compression round ----------------
  logic [31:0]  a_reg, b_reg, c_reg, d_reg, e_reg, f_reg, g_reg, h_reg;
  logic [31:0]  w_reg [0:15];
  logic [5:0]   round_reg;
  logic [31:0]  t1, t2, a_new, e_new, w_new;
  logic [255:0] digest_sum;

  assign t1    = h_reg + big_s1(e_reg) + ((e_reg & f_reg) ^ (~e_reg & g_reg)) +
                 K_TAB[round_reg] + w_reg[0];
  assign t2    = big_s0(a_reg) + ((a_reg & b_reg) ^ (a_reg & c_reg) ^ (b_reg & c_reg));
  assign a_new = t1 + t2;
  assign e_new = d_reg + t1;
  // window holds W[t..t+15]; this is W[t+16]
  assign w_new = small_s1(w_reg[14]) + w_reg[9] + small_s0(w_reg[1]) + w_reg[0];
  assign digest_sum = {IV_TAB[0] + a_new, IV_TAB[1] + a_reg, IV_TAB[2] + b_reg, IV_TAB[3] + c_reg,
                       IV_TAB[4] + e_new, IV_TAB[5] + e_reg, IV_TAB[6] + f_reg, IV_TAB[7] + g_reg};

  // ---------------- control FSM and transmitter ----------------
  logic [255:0]  digest_reg;
  logic [CW-1:0] tx_cnt_reg;
  logic [3:0]    tx_bit_reg;
  logic [4:0]    byte_idx_reg;
  logic          uart_tx_reg, led0_reg;
  logic          tx_next_bit;

  // tx_bit_reg is the frame bit on the line (0 start, 1..8 data, 9 stop)
  assign tx_next_bit = (tx_bit_reg == 4'd8) ? 1'b1 : digest_reg[248 + 32'(tx_bit_reg[2:0])];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      round_reg    <= '0;
      a_reg <= '0; b_reg <= '0; c_reg <= '0; d_reg <= '0;
      e_reg <= '0; f_reg <= '0; g_reg <= '0; h_reg <= '0;
      for (int i = 0; i < 16; i++) w_reg[i] <= '0;
      digest_reg   <= '0;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      byte_idx_reg <= '0;
      uart_tx_reg  <= 1'b1;
      led0_reg     <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (buf_clr) begin
            len_reg   <= '0;
            state_reg <= RECV;
            led0_reg  <= 1'b0;
          end
        end
        RECV: begin
          if (rx_valid_reg) begin
            if (rx_byte_reg == 8'h01)      len_reg   <= '0;
            else if (rx_byte_reg == 8'hff) state_reg <= PAD;
            else if (buf_wr)               len_reg   <= len_reg + 6'd1;
          end
        end
        PAD: begin
          for (int i = 0; i < 16; i++) w_reg[i] <= blk_word[i];
          a_reg <= IV_TAB[0]; b_reg <= IV_TAB[1]; c_reg <= IV_TAB[2]; d_reg <= IV_TAB[3];
          e_reg <= IV_TAB[4]; f_reg <= IV_TAB[5]; g_reg <= IV_TAB[6]; h_reg <= IV_TAB[7];
          round_reg <= '0;
          state_reg <= HASH;
        end
        HASH: begin
          for (int i = 0; i < 15; i++) w_reg[i] <= w_reg[i+1];
          w_reg[15] <= w_new;
          h_reg <= g_reg; g_reg <= f_reg; f_reg <= e_reg; e_reg <= e_new;
          d_reg <= c_reg; c_reg <= b_reg; b_reg <= a_reg; a_reg <= a_new;
          round_reg <= round_reg + 6'd1;
          if (round_reg == 6'd63) begin
            digest_reg   <= digest_sum;
            state_reg    <= SEND;
            uart_tx_reg  <= 1'b0;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            byte_idx_reg <= '0;
          end
        end
        SEND: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg <= '0;
            if (tx_bit_reg == 4'd9) begin
              if (byte_idx_reg == 5'd31) begin
                state_reg   <= IDLE;
                led0_reg    <= 1'b1;
                uart_tx_reg <= 1'b1;
              end else begin
                byte_idx_reg <= byte_idx_reg + 5'd1;
                digest_reg   <= digest_reg << 8;
                tx_bit_reg   <= '0;
                uart_tx_reg  <= 1'b0;
              end
            end else begin
              tx_bit_reg  <= tx_bit_reg + 4'd1;
              uart_tx_reg <= tx_next_bit;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign uart_tx = uart_tx_reg;
  assign led0    = led0_reg;

endmodule

// File: tb/tb_top_wrapper_tang9k.sv
// Directed bench: drives UART frames, captures the 32-byte reply and compares digests.
module tb_top_wrapper_tang9k;
  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int BIT      = CLK_FREQ / BAUD;

  localparam logic [255:0] EMPTY_DIGEST = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] ABC_DIGEST   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;
  logic uart_tx, led0;

  always #5 clk = ~clk;

  top_wrapper_tang9k #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx), .led0(led0)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // reference SHA-256 of ref_msg[0..len-1] (single block, len <= 55)
  logic [7:0] ref_msg [64];

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_ref(input int len);
    logic [7:0]  blk [64];
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    logic [63:0] bl;
    hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int i = 0; i < 64; i++) blk[i] = (i < len) ? ref_msg[i] : 8'h00;
    blk[len] = 8'h80;
    bl = 64'(len * 8);
    for (int i = 0; i < 8; i++) blk[56+i] = bl[63-8*i -: 8];
    for (int t = 0; t < 16; t++) w[t] = {blk[4*t], blk[4*t+1], blk[4*t+2], blk[4*t+3]};
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
             (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d, hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
  endfunction

  // reply capture, sampled on the falling clock edge
  logic [7:0] mon_q [$];
  int start_cnt = 0;
  int first_start_cyc = -1;

  initial begin : monitor
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !uart_tx) begin
        start_cnt++;
        if (first_start_cyc < 0) first_start_cyc = cyc;
        repeat (BIT/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (BIT) @(negedge clk);
        mon_q.push_back(b);
      end
      prev = uart_tx;
    end
  end

  // stimulus
  logic [7:0] frm [$];
  int bad_idx = -1;
  int stop_mid_cyc = 0;

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx = stop_bit;
    stop_mid_cyc = cyc + BIT/2;
    repeat (BIT) @(negedge clk);
    uart_rx = 1'b1;
    if (!stop_bit) repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame();
    for (int i = 0; i < frm.size(); i++) send_byte(frm[i], (i == bad_idx) ? 1'b0 : 1'b1);
  endtask

  task automatic clear_capture();
    mon_q.delete();
    first_start_cyc = -1;
    bad_idx = -1;
  endtask

  task automatic expect_digest(input string tag, input logic [255:0] exp);
    logic [255:0] got;
    int waited;
    waited = 0;
    while (mon_q.size() < 32 && waited < 6000) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_nbytes"}, 256'(mon_q.size()), 256'd32);
    got = '0;
    for (int i = 0; i < 32 && i < mon_q.size(); i++) got = {got[247:0], mon_q[i]};
    check({tag, "_digest"}, got, exp);
    check({tag, "_led_busy_last_stop"}, 256'(led0), 256'd0);
    repeat (BIT) @(negedge clk);
    check({tag, "_led_idle"}, 256'(led0), 256'd1);
    check({tag, "_tx_idle"}, 256'(uart_tx), 256'd1);
    $display("frame %s: %0d bytes, digest %h", tag, mon_q.size(), got);
  endtask

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: observed timeout, expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int snap;
    int waited;
    logic [255:0] exp;

    repeat (3) @(negedge clk);
    check("reset_tx", 256'(uart_tx), 256'd1);
    check("reset_led", 256'(led0), 256'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // empty message
    clear_capture();
    send_byte(8'h01, 1'b1);
    check("empty_led_after_01", 256'(led0), 256'd0);
    send_byte(8'hff, 1'b1);
    expect_digest("empty", EMPTY_DIGEST);

    // "abc"
    clear_capture();
    frm = '{8'h01, 8'h61, 8'h62, 8'h63, 8'hff};
    send_frame();
    expect_digest("abc", ABC_DIGEST);

    // "TEST" plus turnaround latency
    clear_capture();
    frm = '{8'h01, 8'h54, 8'h45, 8'h53, 8'h54, 8'hff};
    ref_msg[0] = 8'h54; ref_msg[1] = 8'h45; ref_msg[2] = 8'h53; ref_msg[3] = 8'h54;
    exp = sha_ref(4);
    send_frame();
    expect_digest("test", exp);
    check("test_latency_le_100",
          256'((first_start_cyc >= stop_mid_cyc) && (first_start_cyc - stop_mid_cyc <= 100)), 256'd1);

    // restart inside a frame
    clear_capture();
    frm = '{8'h01, 8'h61, 8'h01, 8'h61, 8'h62, 8'h63, 8'hff};
    send_frame();
    expect_digest("restart", ABC_DIGEST);

    // stray bytes in idle produce nothing
    clear_capture();
    snap = start_cnt;
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    repeat (400) @(negedge clk);
    check("stray_no_tx", 256'(start_cnt), 256'(snap));
    check("stray_led_idle", 256'(led0), 256'd1);

    // framing error drops 0x62, leaving "ac"
    clear_capture();
    frm = '{8'h01, 8'h61, 8'h62, 8'h63, 8'hff};
    bad_idx = 2;
    ref_msg[0] = 8'h61; ref_msg[1] = 8'h63;
    exp = sha_ref(2);
    send_frame();
    expect_digest("bad_stop", exp);

    // 60 payload bytes truncate to 55
    clear_capture();
    frm.delete();
    frm.push_back(8'h01);
    for (int i = 0; i < 60; i++) frm.push_back(8'h61);
    frm.push_back(8'hff);
    for (int i = 0; i < 55; i++) ref_msg[i] = 8'h61;
    exp = sha_ref(55);
    send_frame();
    expect_digest("len60", exp);

    // reset while transmitting
    clear_capture();
    snap = start_cnt;
    frm = '{8'h01, 8'hff};
    send_frame();
    waited = 0;
    while (!((start_cnt >= snap + 3) && (uart_tx == 1'b0)) && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check("rst_reached_send", 256'(uart_tx == 1'b0), 256'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx_immediate", 256'(uart_tx), 256'd1);
    check("rst_led_immediate", 256'(led0), 256'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    snap = start_cnt;
    repeat (400) @(negedge clk);
    check("rst_no_more_tx", 256'(start_cnt), 256'(snap));
    check("rst_led_idle", 256'(led0), 256'd1);
    $display("reset during send: %0d start bits before reset", snap);

    // recovery frame
    clear_capture();
    frm = '{8'h01, 8'hff};
    send_frame();
    expect_digest("after_rst", EMPTY_DIGEST);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/top_wrapper_tang9k.md
TOP_WRAPPER_TANG9K -- requirements
Module: top_wrapper_tang9k

Interface
REQ-001 Parameter CLK_FREQ, default 27000000, SHALL set the clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, SHALL set the UART bit rate.
REQ-003 Port clk SHALL be an input, 1 bit: the single system clock.
REQ-004 Port rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port uart_rx SHALL be an input, 1 bit: asynchronous UART receive line, idle high.
REQ-006 Port uart_tx SHALL be an output, 1 bit: UART transmit line, idle high.
REQ-007 Port led0 SHALL be an output, 1 bit: active-low busy indicator.

Function
REQ-008 UART SHALL use 8N1 format, LSB first; bit time = CLK_FREQ/BAUD_RATE clocks, integer-truncated (234 at defaults).
REQ-009 RX SHALL pass uart_rx through a 2-FF synchronizer before any use.
REQ-010 RX SHALL detect start on a falling edge and re-check low at mid-bit (else return to idle); it SHALL sample data at mid-bit and accept the byte only if the stop bit samples 1.
REQ-011 A byte failing the stop-bit check SHALL be discarded silently.
REQ-012 Control FSM states SHALL be IDLE, RECV, PAD, HASH, SEND.
REQ-013 IDLE: byte 0x01 -> clear buffer and length, go to RECV; all other bytes are ignored.
REQ-014 RECV: 0xFF -> PAD; 0x01 -> clear buffer and restart RECV; any other byte -> append, up to 55 bytes.
REQ-015 RECV: payload bytes beyond the 55th SHALL be dropped; the hash covers the first 55 only.
REQ-016 PAD SHALL build one 512-bit block: payload bytes, then 0x80, zero fill, then 64-bit big-endian bit length (8*len) in the last 8 bytes; zero-length payload is legal.
REQ-017 HASH SHALL run standard FIPS 180-4 SHA-256 on that single block from the standard IV H0..H7, one round per clock (64 rounds), then add the working variables to the IV.
REQ-018 Message schedule SHALL use a 16-word sliding window; all arithmetic is mod 2^32.
REQ-019 SEND SHALL transmit the 32 digest bytes, H0 most-significant byte first through H7 least-significant byte, back to back with 1 stop bit each, then return to IDLE.
REQ-020 The first start bit SHALL begin within 100 clocks of the 0xFF stop-bit sample.
REQ-021 Bytes received during PAD, HASH or SEND SHALL be ignored; reception resumes in IDLE.
REQ-022 led0 SHALL be 0 in RECV, PAD, HASH and SEND, and 1 in IDLE.
REQ-023 uart_tx SHALL be 1 whenever no byte is being sent.

Reset
REQ-024 rst_n=0 SHALL immediately force: FSM=IDLE, uart_tx=1, led0=1, buffer and length cleared, RX/TX bit counters cleared, digest registers cleared.
REQ-025 Reset asserted mid-frame, mid-hash or mid-transmit SHALL abort the operation, with no partial byte completed after release.
REQ-026 After reset release the block SHALL accept a new frame within one bit time.

Verification
REQ-027 Frame 01 FF -> 32 bytes e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; led0 low from 0x01 until the last stop bit.
REQ-028 Frame 01 61 62 63 FF ("abc") -> ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-029 Frame 01 54 45 53 54 FF ("TEST") -> 32 bytes matching a software SHA-256("TEST") model; the first start bit begins within 100 clocks of the 0xFF stop bit.
REQ-030 Frame 01 61 01 61 62 63 FF -> same digest as the "abc" case (restart on 0x01); stray bytes 41 42 before the frame -> no output.
REQ-031 Byte with stop bit forced 0 inside a frame -> byte dropped, and the digest equals the digest of the frame without it; frame of 60 x 0x61 -> digest of 55 x 0x61.
REQ-032 rst_n pulsed low during SEND -> uart_tx=1 and led0=1 immediately, no further bytes; a following 01 FF frame -> correct empty-message digest.
